apb_slave_regs: RTL

APB completer that sits directly downstream of the APB master on the shared APB interface. It decodes psel/penable/pwrite/paddr, inserts a parameterised number of wait states and drives pready. It holds a small word-addressed register bank that is written on pwdata and read back on prdata. It lets the master be exercised against a real responder instead of testbench-generated pready/prdata.

---
 rtl/apb_slave_pkg.sv | 19 +
 rtl/apb_regfile.sv | 41 ++++
 rtl/apb_slave_regs.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg
// Shared types and constants for the APB register-bank completer.
//   apb_state_t  : transfer FSM states (IDLE, WAIT, DONE)
//   APB_ADDR_W   : default paddr width
//   APB_DATA_W   : default pwdata/prdata width
//   WORD_IDX_LSB : lowest paddr bit of the word index (registers are 32-bit words)
package apb_slave_pkg;

  localparam int APB_ADDR_W   = 32;
  localparam int APB_DATA_W   = 32;
  localparam int WORD_IDX_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_regfile.sv
// apb_regfile
// NUM_REGS x DATA_W register storage with one synchronous write port and one
// combinational read port. NUM_REGS is expected to be a power of two so that
// every index value selects a real entry.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset, clears every entry
//   we     : write enable
//   widx   : write word index
//   wdata  : write data
//   ridx   : read word index
//   rdata  : read data (combinational from ridx)
module apb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int IDX_W   = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[widx] <= wdata;
    end
  end

  assign rdata = regs[ridx];

endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs
// APB completer with a parameterised number of wait states and a small
// word-addressed register bank. All outputs are registered.
// Optional feature macro: APB_SLVERR_EN
//   defined   : misaligned or out-of-range addresses complete with pslverr=1,
//               writes are dropped and reads return 0
//   undefined : pslverr stays 0 and the word index wraps modulo NUM_REGS
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   psel    : APB select
//   penable : APB access phase
//   pwrite  : 1 = write, 0 = read
//   paddr   : byte address
//   pwdata  : write data
//   prdata  : read data, valid with pready on reads
//   pready  : transfer complete
//   pslverr : error response, only ever high together with pready
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  apb_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              pready_next;
  logic              pslverr_next;
  logic              rd_load;
  logic              reg_we;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic              addr_err;
  logic              slverr_hit;

  assign word_idx = paddr[IDX_W+WORD_IDX_LSB-1:WORD_IDX_LSB];

  // Any address bit above the index, or a non-word-aligned byte offset.
  assign addr_err = ((paddr >> (IDX_W + WORD_IDX_LSB)) != '0) || (paddr[1:0] != 2'b00);

`ifdef APB_SLVERR_EN
  assign slverr_hit = addr_err;
`else
  logic unused_addr_err;
  assign unused_addr_err = addr_err;
  assign slverr_hit      = 1'b0;
`endif

  apb_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .widx  (word_idx),
    .wdata (pwdata),
    .ridx  (word_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pready_q  <= pready_next;
      pslverr_q <= pslverr_next;
      if (rd_load) begin
        prdata_q <= slverr_hit ? '0 : rd_data;
      end
    end
  end

  // pready is registered, so the decision to complete is taken one cycle
  // early: from the setup phase when there are no wait states, otherwise
  // from the last WAIT cycle (cnt == 1). Read data is captured on that
  // same edge so it appears together with pready.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    rd_load      = 1'b0;
    reg_we       = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          if (WAIT_CYCLES == 0) begin
            state_next   = DONE;
            pready_next  = 1'b1;
            pslverr_next = slverr_hit;
            rd_load      = !pwrite;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_next   = DONE;
          cnt_next     = '0;
          pready_next  = 1'b1;
          pslverr_next = slverr_hit;
          rd_load      = !pwrite;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        reg_we     = psel && penable && pwrite && !slverr_hit;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
